// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among NREQ byte-stream requesters.
// A winner holds the UART for its whole packet until it sends a last byte or its lock times out.
module uart_tx_arbiter #(
   parameter int NREQ         = 4,
   parameter int IDW          = 2,
   parameter int LOCK_TIMEOUT = 65535
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [NREQ-1:0]   req_valid,
   input  logic [8*NREQ-1:0] req_data,
   input  logic [NREQ-1:0]   req_last,
   output logic [NREQ-1:0]   req_ready,
   output logic [7:0]        uart_tx_data,
   output logic              uart_tx_start,
   input  logic              uart_tx_busy,
   output logic              active,
   output logic [IDW-1:0]    grant_id,
   output logic              lock_timeout
);

   localparam int TW = $clog2(LOCK_TIMEOUT + 1);
   localparam logic [TW-1:0] TMO_LAST = TW'(LOCK_TIMEOUT - 1);

   typedef enum logic [1:0] {StIdle, StSend, StWaitBusy, StWaitDone} state_e;

   state_e          state_q, state_d;
   logic [IDW-1:0]  grant_q, grant_d;
   logic [IDW-1:0]  rr_q, rr_d;
   logic [TW-1:0]   tmo_q, tmo_d;
   logic            last_q, last_d;
   logic [NREQ-1:0] ready_q, ready_d;
   logic            start_q, start_d;
   logic [7:0]      data_q, data_d;
   logic            tmo_pulse_q, tmo_pulse_d;

   logic [IDW-1:0]  pick;
   logic            pick_vld;
   logic            cur_valid;
   logic            cur_last;
   logic [7:0]      cur_data;

   // First requesting index after the last served one, wrapping modulo NREQ.
   always_comb begin
      pick     = '0;
      pick_vld = 1'b0;
      for (int k = 1; k <= NREQ; k++) begin
         int idx;
         idx = (int'(rr_q) + k) % NREQ;
         if (!pick_vld && req_valid[idx]) begin
            pick     = IDW'(idx);
            pick_vld = 1'b1;
         end
      end
   end

   always_comb begin
      cur_valid = 1'b0;
      cur_last  = 1'b0;
      cur_data  = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (grant_q == IDW'(i)) begin
            cur_valid = req_valid[i];
            cur_last  = req_last[i];
            cur_data  = req_data[8*i +: 8];
         end
      end
   end

   always_comb begin
      state_d     = state_q;
      grant_d     = grant_q;
      rr_d        = rr_q;
      tmo_d       = tmo_q;
      last_d      = last_q;
      ready_d     = '0;
      start_d     = 1'b0;
      data_d      = data_q;
      tmo_pulse_d = 1'b0;
      unique case (state_q)
         StIdle: begin
            tmo_d = '0;
            if (pick_vld) begin
               grant_d = pick;
               state_d = StSend;
            end
         end
         StSend: begin
            if (cur_valid) begin
               ready_d = NREQ'(1) << grant_q;
               start_d = 1'b1;
               data_d  = cur_data;
               last_d  = cur_last;
               tmo_d   = '0;
               state_d = StWaitBusy;
            end else if (tmo_q == TMO_LAST) begin
               tmo_pulse_d = 1'b1;
               rr_d        = grant_q;
               tmo_d       = '0;
               state_d     = StIdle;
            end else begin
               tmo_d = tmo_q + 1'b1;
            end
         end
         StWaitBusy: begin
            if (uart_tx_busy) state_d = StWaitDone;
         end
         StWaitDone: begin
            if (!uart_tx_busy) begin
               if (last_q) begin
                  rr_d    = grant_q;
                  state_d = StIdle;
               end else begin
                  state_d = StSend;
               end
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= StIdle;
         grant_q     <= '0;
         rr_q        <= IDW'(NREQ - 1);
         tmo_q       <= '0;
         last_q      <= 1'b0;
         ready_q     <= '0;
         start_q     <= 1'b0;
         data_q      <= '0;
         tmo_pulse_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         grant_q     <= grant_d;
         rr_q        <= rr_d;
         tmo_q       <= tmo_d;
         last_q      <= last_d;
         ready_q     <= ready_d;
         start_q     <= start_d;
         data_q      <= data_d;
         tmo_pulse_q <= tmo_pulse_d;
      end
   end

   assign req_ready     = ready_q;
   assign uart_tx_start = start_q;
   assign uart_tx_data  = data_q;
   assign grant_id      = grant_q;
   assign lock_timeout  = tmo_pulse_q;
   assign active        = (state_q != StIdle);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter with a behavioural UART (BAUD_DIV=4, 40-cycle frame).
// Expected grants are queued as stimulus is issued; a monitor pops them on every uart_tx_start.
module tb_uart_tx_arbiter;

   localparam int NREQ         = 4;
   localparam int IDW          = 2;
   localparam int LOCK_TIMEOUT = 16;
   localparam int BAUD_DIV     = 4;
   localparam int BUDGET       = 3000;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic [NREQ-1:0]   req_valid = '0;
   logic [8*NREQ-1:0] req_data = '0;
   logic [NREQ-1:0]   req_last = '0;
   logic [NREQ-1:0]   req_ready;
   logic [7:0]        uart_tx_data;
   logic              uart_tx_start;
   logic              uart_tx_busy;
   logic              active;
   logic [IDW-1:0]    grant_id;
   logic              lock_timeout;

   uart_tx_arbiter #(
      .NREQ         (NREQ),
      .IDW          (IDW),
      .LOCK_TIMEOUT (LOCK_TIMEOUT)
   ) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .req_valid     (req_valid),
      .req_data      (req_data),
      .req_last      (req_last),
      .req_ready     (req_ready),
      .uart_tx_data  (uart_tx_data),
      .uart_tx_start (uart_tx_start),
      .uart_tx_busy  (uart_tx_busy),
      .active        (active),
      .grant_id      (grant_id),
      .lock_timeout  (lock_timeout)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Behavioural UART: busy rises the cycle after start, 10 bits of BAUD_DIV cycles each.
   int         u_cnt;
   int         u_bit;
   logic [9:0] u_shift;
   logic       tx_line;
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         uart_tx_busy <= 1'b0;
         tx_line      <= 1'b1;
         u_cnt        <= 0;
         u_bit        <= 0;
         u_shift      <= '1;
      end else if (!uart_tx_busy) begin
         if (uart_tx_start) begin
            uart_tx_busy <= 1'b1;
            u_shift      <= {1'b1, uart_tx_data, 1'b0};
            tx_line      <= 1'b0;
            u_cnt        <= 0;
            u_bit        <= 0;
         end
      end else if (u_cnt == BAUD_DIV - 1) begin
         u_cnt <= 0;
         if (u_bit == 9) begin
            uart_tx_busy <= 1'b0;
            tx_line      <= 1'b1;
         end else begin
            u_bit   <= u_bit + 1;
            tx_line <= u_shift[u_bit+1];
         end
      end else begin
         u_cnt <= u_cnt + 1;
      end
   end

   typedef struct {
      int         id;
      logic       last;
      logic [7:0] d;
   } item_t;

   typedef struct {
      int         id;
      logic [7:0] d;
   } exp_t;

   item_t      pend[$];
   exp_t       exp_q[$];
   logic [7:0] line_q[$];

   int         n_checks = 0;
   int         n_fail = 0;
   int         last_start_cyc = 0;
   int         last_fall_cyc = 0;
   int         fall_at_tmo = 0;
   int         tmo_cyc = 0;
   int         tmo_pulses = 0;
   logic [9:0] last_frame = '0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_checks++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
      end
   endtask

   task automatic fail(input string name);
      n_checks++;
      n_fail++;
      $display("FAIL %s: event missing or unexpected", name);
   endtask

   task automatic give(input int id, input logic [7:0] d, input logic last);
      item_t it;
      it.id   = id;
      it.d    = d;
      it.last = last;
      pend.push_back(it);
   endtask

   task automatic expect_byte(input int id, input logic [7:0] d);
      exp_t e;
      e.id = id;
      e.d  = d;
      exp_q.push_back(e);
   endtask

   // Requester model: retire acked bytes, then present each requester's oldest pending byte.
   task automatic tick();
      @(negedge clk);
      for (int i = 0; i < NREQ; i++) begin
         if (req_ready[i]) begin
            for (int j = 0; j < pend.size(); j++) begin
               if (pend[j].id == i) begin
                  pend.delete(j);
                  break;
               end
            end
         end
      end
      req_valid = '0;
      req_last  = '0;
      req_data  = '0;
      for (int i = 0; i < NREQ; i++) begin
         for (int j = 0; j < pend.size(); j++) begin
            if (pend[j].id == i) begin
               req_valid[i]        = 1'b1;
               req_last[i]         = pend[j].last;
               req_data[8*i +: 8]  = pend[j].d;
               break;
            end
         end
      end
   endtask

   task automatic wait_idle(input string name);
      int n;
      n = 0;
      tick();
      while ((pend.size() != 0 || exp_q.size() != 0 || active || uart_tx_busy) && n < BUDGET) begin
         tick();
         n++;
      end
      if (n >= BUDGET) fail(name);
      repeat (2) tick();
   endtask

   task automatic pulse_reset();
      @(negedge clk);
      #2 rst_n = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
   endtask

   // Monitor: pops the scoreboard on every start, reassembles the TX line per frame.
   initial begin
      exp_t       e;
      logic [7:0] d;
      logic [9:0] frame;
      logic       prev_busy;
      prev_busy = 1'b0;
      frame     = '1;
      forever begin
         @(posedge clk);
         #1;
         if (!rst_n) begin
            line_q.delete();
            prev_busy = 1'b0;
            frame     = '1;
         end else begin
            if (uart_tx_start || uart_tx_busy)
               check("start_vs_busy", 32'(uart_tx_start & uart_tx_busy), 0);
            if (uart_tx_start || req_ready != '0) begin
               if (exp_q.size() == 0) begin
                  check("unexpected_start", 32'({req_ready, uart_tx_start}), 0);
               end else begin
                  e = exp_q.pop_front();
                  check("start_pulse", 32'(uart_tx_start), 1);
                  check("grant_id", 32'(grant_id), 32'(e.id));
                  check("tx_data", 32'(uart_tx_data), 32'(e.d));
                  check("req_ready", 32'(req_ready), 32'(1) << e.id);
                  line_q.push_back(e.d);
                  last_start_cyc = cyc;
               end
            end
            if (uart_tx_busy && u_cnt == 1) frame[u_bit] = tx_line;
            if (prev_busy && !uart_tx_busy) begin
               last_fall_cyc = cyc;
               if (line_q.size() > 0) begin
                  d = line_q.pop_front();
                  check("tx_frame", 32'(frame), 32'({1'b1, d, 1'b0}));
                  last_frame = frame;
               end else begin
                  fail("unexpected_frame");
               end
            end
            if (lock_timeout) begin
               tmo_pulses++;
               tmo_cyc     = cyc;
               fall_at_tmo = last_fall_cyc;
            end
            prev_busy = uart_tx_busy;
         end
      end
   end

   initial begin
      int n;
      int valid_cyc;

      repeat (3) @(negedge clk);
      check("rst_req_ready", 32'(req_ready), 0);
      check("rst_tx_start", 32'(uart_tx_start), 0);
      check("rst_tx_data", 32'(uart_tx_data), 0);
      check("rst_grant_id", 32'(grant_id), 0);
      check("rst_active", 32'(active), 0);
      check("rst_lock_timeout", 32'(lock_timeout), 0);
      rst_n = 1'b1;

      // 1: single-byte packet, start two cycles after valid, frame 0,1,0,1,0,0,1,0,1,1.
      give(0, 8'hA5, 1'b1);
      expect_byte(0, 8'hA5);
      tick();
      valid_cyc = cyc;
      wait_idle("s1_idle");
      check("s1_latency", 32'(last_start_cyc - valid_cyc), 2);
      check("s1_line", 32'(last_frame), 32'(10'b1101001010));
      check("s1_active", 32'(active), 0);

      // 2: from reset, requesters 0, 1, 3 (0 twice) -> grant order 0,1,3,0.
      pulse_reset();
      give(0, 8'hB0, 1'b1);
      give(0, 8'hB1, 1'b1);
      give(1, 8'hC1, 1'b1);
      give(3, 8'hD3, 1'b1);
      expect_byte(0, 8'hB0);
      expect_byte(1, 8'hC1);
      expect_byte(3, 8'hD3);
      expect_byte(0, 8'hB1);
      wait_idle("s2_idle");

      // 3: req1 keeps the lock over three bytes while req2 waits.
      give(1, 8'h11, 1'b0);
      give(1, 8'h22, 1'b0);
      give(1, 8'h33, 1'b1);
      give(2, 8'h44, 1'b1);
      expect_byte(1, 8'h11);
      expect_byte(1, 8'h22);
      expect_byte(1, 8'h33);
      expect_byte(2, 8'h44);
      wait_idle("s3_idle");

      // 4: req2 stalls mid-packet; req3 waits out the timeout then wins.
      give(2, 8'h55, 1'b0);
      expect_byte(2, 8'h55);
      n = 0;
      while (pend.size() != 0 && n < BUDGET) begin
         tick();
         n++;
      end
      if (n >= BUDGET) fail("s4_ack_wait");
      give(3, 8'h77, 1'b1);
      expect_byte(3, 8'h77);
      wait_idle("s4_idle");
      check("s4_tmo_count", 32'(tmo_pulses), 1);
      // Busy low first seen at F, SEND entered at F+1, pulse 16 cycles later.
      check("s4_tmo_delay", 32'(tmo_cyc - fall_at_tmo), 17);

      // 5: reset while the UART is mid-frame.
      give(1, 8'h88, 1'b1);
      expect_byte(1, 8'h88);
      n = 0;
      while (!uart_tx_busy && n < 200) begin
         tick();
         n++;
      end
      if (n >= 200) fail("s5_busy_wait");
      repeat (5) tick();
      check("s5_pre_active", 32'(active), 1);
      check("s5_pre_grant", 32'(grant_id), 1);
      #2 rst_n = 1'b0;
      #1;
      check("s5_rst_req_ready", 32'(req_ready), 0);
      check("s5_rst_tx_start", 32'(uart_tx_start), 0);
      check("s5_rst_tx_data", 32'(uart_tx_data), 0);
      check("s5_rst_grant_id", 32'(grant_id), 0);
      check("s5_rst_active", 32'(active), 0);
      check("s5_rst_lock_timeout", 32'(lock_timeout), 0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      give(2, 8'hAA, 1'b1);
      give(0, 8'h99, 1'b1);
      expect_byte(0, 8'h99);
      expect_byte(2, 8'hAA);
      wait_idle("s5_idle");

      check("exp_drained", 32'(exp_q.size()), 0);
      check("tmo_total", 32'(tmo_pulses), 1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

endmodule
